// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_ACK,
    ST_RECOVER
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NOACK   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET_KB = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, accepts a new level only after FILTER_LEN
// consecutive equal samples, and pulses fall when the accepted level goes 1 -> 0.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines float high, so everything resets to the released level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command sender: inhibit, request-to-send, shift 8 data
// bits + odd parity on device clock falls, release for stop, then check the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output ps2_state_t fsm_state
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t    state, next_state;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    code_q;
  logic          done_q, err_q;

  logic clk_level, clk_fall, data_level, data_fall_unused;
  logic inh_last, timeout_hit, cur_bit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .reset (reset),
    .line  (ps2_data_in),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  assign inh_last    = (inh_cnt == INH_LAST);
  assign timeout_hit = (to_cnt == TO_LAST);
  // bit_cnt 0..7 selects data (LSB first), 8 selects the parity bit.
  assign cur_bit     = bit_cnt[3] ? parity_q : data_q[bit_cnt[2:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      data_q   <= '0;
      parity_q <= 1'b0;
      bit_cnt  <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      code_q   <= ERR_NONE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            data_q   <= tx_data;
            parity_q <= odd_parity(tx_data);
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            code_q   <= ERR_NONE;
          end
        end
        ST_INHIBIT: begin
          if (inh_last) to_cnt <= '0;
          else          inh_cnt <= inh_cnt + 1'b1;
        end
        ST_REQUEST, ST_SHIFT, ST_ACK: begin
          if (clk_fall) begin
            to_cnt <= '0;
            if (state == ST_SHIFT && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
            if (state == ST_ACK) begin
              if (!data_level) begin
                done_q <= 1'b1;
              end else begin
                err_q  <= 1'b1;
                code_q <= ERR_NOACK;
              end
            end
          end else if (timeout_hit) begin
            err_q  <= 1'b1;
            code_q <= ERR_TIMEOUT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (tx_valid) next_state = ST_INHIBIT;
      ST_INHIBIT: if (inh_last) next_state = ST_REQUEST;
      ST_REQUEST: begin
        if (clk_fall)         next_state = ST_SHIFT;
        else if (timeout_hit) next_state = ST_RECOVER;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          if (bit_cnt == 4'd8) next_state = ST_ACK;
        end else if (timeout_hit) begin
          next_state = ST_RECOVER;
        end
      end
      ST_ACK:     if (clk_fall || timeout_hit) next_state = ST_RECOVER;
      ST_RECOVER: if (clk_level && data_level) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Handshake: a byte is taken on any clk edge where tx_valid && tx_ready.
  always_comb begin
    tx_ready    = (state == ST_IDLE);
    ps2_clk_oe  = (state == ST_INHIBIT);
    ps2_data_oe = 1'b0;
    case (state)
      ST_INHIBIT: ps2_data_oe = inh_last;
      ST_REQUEST: ps2_data_oe = 1'b1;
      ST_SHIFT:   ps2_data_oe = ~cur_bit;
      default:    ps2_data_oe = 1'b0;
    endcase
  end

  assign rx_inhibit = ~tx_ready;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model on both lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 300;
  localparam int FL   = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       rx_inhibit, done, err;
  logic [1:0] err_code;
  ps2_state_t fsm_state;

  logic dev_clk = 1'b1, dev_data = 1'b1, glitch = 1'b0;

  // Wired-AND open-drain lines: host pulls low via oe, device via its own drivers.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk & ~glitch;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_inhibit  (rx_inhibit),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0;
  logic [10:0] exp_q[$];

  int done_cnt = 0, err_cnt = 0, both_cnt = 0, dbl_cnt = 0, accept_cnt = 0;
  logic done_prev = 1'b0;
  ps2_state_t st_prev = ST_IDLE;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    if (done && done_prev) dbl_cnt++;
    if (fsm_state == ST_INHIBIT && st_prev != ST_INHIBIT) accept_cnt++;
    done_prev = done;
    st_prev   = fsm_state;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    ok = tx_ready;
  endtask

  // Keyboard model: counts the inhibit window, then clocks 11 falls and
  // records the line level at the end of each low phase (start, 8 data, parity, stop).
  task automatic dev_frame(input bit ack, input bit glt, input int abort_edge,
                           output logic [10:0] frame, output int inh, output int inh_d,
                           output bit ok);
    int n = 0;
    frame = '0;
    inh   = 0;
    inh_d = 0;
    ok    = 1'b1;
    while (!ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_oe && n < 1000) begin
      inh++;
      if (ps2_data_oe) inh_d++;
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      ok = 1'b0;
      return;
    end
    repeat (10) @(negedge clk);
    frame[0] = ps2_data_in;
    for (int e = 1; e <= 11; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (e <= 10) frame[e] = ps2_data_in;
      if (e == abort_edge) return;
      dev_clk = 1'b1;
      if (e == 11) begin
        dev_data = 1'b1;
        return;
      end
      if (e == 10 && ack) dev_data = 1'b0;
      if (glt && e >= 2 && e <= 9) begin
        repeat (10) @(negedge clk);
        glitch = 1'b1;
        repeat (FL - 1) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - 10 - (FL - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    bit          glitch;
    bit          hold;
    logic [10:0] frame;
    bit          exp_done;
    logic [1:0]  code;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int d0, e0, a0, inh, inh_d;
    logic [10:0] fr;
    bit ok;
    wait_idle(ok);
    chk({tag, " ready_before"}, 32'(ok), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    a0 = accept_cnt;
    tx_data  = v.data;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'($urandom_range(0, 255));
    if (!v.hold) tx_valid = 1'b0;
    exp_q.push_back(v.frame);
    dev_frame(v.ack, v.glitch, 0, fr, inh, inh_d, ok);
    tx_valid = 1'b0;
    chk({tag, " model_ok"}, 32'(ok), 32'd1);
    chk({tag, " frame"}, 32'(fr), 32'(exp_q.pop_front()));
    chk({tag, " inhibit_cycles"}, 32'(inh), 32'(INH));
    chk({tag, " inhibit_data_cycles"}, 32'(inh_d), 32'd1);
    wait_idle(ok);
    chk({tag, " ready_after"}, 32'(ok), 32'd1);
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(v.exp_done));
    chk({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(!v.exp_done));
    chk({tag, " err_code"}, 32'(err_code), 32'(v.code));
    chk({tag, " accepts"}, 32'(accept_cnt - a0), 32'd1);
    chk({tag, " lines_released"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, e0, n, cnt, inh, inh_d;
    logic [10:0] fr;
    bit ok;
    vec_t vff;

    // frame = {stop, parity, data[7:0], start}
    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 11'h7DA, 1'b1, 2'b00};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 1'b0, 11'h600, 1'b1, 2'b00};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 11'h402, 1'b1, 2'b00};
    vecs[3] = '{8'hEE, 1'b1, 1'b1, 1'b0, 11'h7DC, 1'b1, 2'b00};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b0, 11'h7FE, 1'b0, 2'b01};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 11'h500, 1'b1, 2'b00};
    vff     = '{8'hFF, 1'b1, 1'b0, 1'b0, 11'h7FE, 1'b1, 2'b00};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset tx_ready", 32'(tx_ready), 32'd1);
    chk("reset oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("reset done_err", 32'({done, err}), 32'd0);
    chk("reset err_code", 32'(err_code), 32'd0);
    chk("reset rx_inhibit", 32'(rx_inhibit), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Device never clocks: timeout counted from the first REQUEST cycle.
    wait_idle(ok);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = CMD_ECHO;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout request_seen", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    cnt = 0;
    while (!err && cnt < 2 * TO) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout cycles", 32'(cnt), 32'(TO));
    chk("timeout err_code", 32'(err_code), 32'(ERR_TIMEOUT));
    chk("timeout oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    wait_idle(ok);
    chk("timeout idle", 32'(ok), 32'd1);
    chk("timeout done_pulses", 32'(done_cnt - d0), 32'd0);
    chk("timeout err_pulses", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of a frame, after data bit 4 has been sampled.
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(1'b1, 1'b0, 5, fr, inh, inh_d, ok);
    chk("midreset partial_frame", 32'(fr[5:0]), 32'h0A);
    reset = 1'b1;
    #1;
    chk("midreset oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("midreset tx_ready", 32'(tx_ready), 32'd1);
    chk("midreset rx_inhibit", 32'(rx_inhibit), 32'd0);
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    reset    = 1'b0;
    repeat (20) @(negedge clk);
    chk("midreset err_code", 32'(err_code), 32'd0);
    chk("midreset no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    run_vec(vff, "after_reset");

    chk("done_err_overlap", 32'(both_cnt), 32'd0);
    chk("done_pulse_width", 32'(dbl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
